// File: rtl/rtx_pixel_scheduler.sv
// rtx_pixel_scheduler
// Walks a frame in raster order, handing one pixel job per cycle to an idle
// rtx core, and merges the cores' finished pixels round-robin onto a single
// valid/ready port toward the frame buffer (clk_camera domain).
// Optional build macro: RTX_SCHED_STATS_EN adds frame_cycles / max_inflight.
module rtx_pixel_scheduler #(
    parameter int N_CORES    = 4,
    parameter int H_RES      = 1280,
    parameter int V_RES      = 720,
    parameter int CONTINUOUS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [N_CORES-1:0]     core_ready,
    output logic [N_CORES-1:0]     core_start,
    output logic [10:0]            disp_h,
    output logic [9:0]             disp_v,
    input  logic [N_CORES-1:0]     res_valid,
    output logic [N_CORES-1:0]     res_ready,
    input  logic [16*N_CORES-1:0]  res_pixel,
    input  logic [11*N_CORES-1:0]  res_h,
    input  logic [10*N_CORES-1:0]  res_v,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_pixel,
    output logic [10:0]            out_h,
    output logic [9:0]             out_v,
    output logic                   busy,
    output logic                   frame_done
`ifdef RTX_SCHED_STATS_EN
    ,
    output logic [31:0]            frame_cycles,
    output logic [3:0]             max_inflight
`endif
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int TOTAL = H_RES * V_RES;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [10:0]       ptr_h;
    logic [9:0]        ptr_v;
    logic [IDX_W-1:0]  dsp_rr, col_rr;
    logic [IDX_W-1:0]  dsp_g, col_g;
    logic [N_CORES-1:0] dsp_avail, col_req;
    logic              dsp_fire, dsp_last, col_fire, can_load, hs, enter;
    logic [CNT_W-1:0]  out_cnt;
    logic              done_flag;

    // First requesting index at or after ptr, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(ptr) + k) % N_CORES;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
        return IDX_W'((int'(g) + 1) % N_CORES);
    endfunction

    // A core whose core_start is still high has not yet dropped core_ready.
    assign dsp_avail = core_ready & ~core_start;
    assign dsp_fire  = (state == DISPATCH) && !stop && (|dsp_avail);
    assign dsp_g     = rr_pick(dsp_avail, dsp_rr);
    assign dsp_last  = (ptr_h == 11'(H_RES - 1)) && (ptr_v == 10'(V_RES - 1));

    // Results are only accepted while a frame is active.
    assign col_req   = (state != IDLE) ? res_valid : '0;
    assign hs        = out_valid && out_ready;
    assign can_load  = !out_valid || out_ready;
    assign col_fire  = can_load && (|col_req);
    assign col_g     = rr_pick(col_req, col_rr);

    assign frame_done = hs && (state != IDLE) && (out_cnt == CNT_W'(TOTAL - 1));
    assign busy       = (state != IDLE);
    assign enter      = (state == IDLE) && (state_nxt == DISPATCH);

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start || ((CONTINUOUS != 0) && done_flag)) state_nxt = DISPATCH;
            DISPATCH: if (dsp_fire && dsp_last) state_nxt = DRAIN;
            DRAIN:    if (frame_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register plus the "previous frame finished" flag for auto-restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enter)           done_flag <= 1'b0;
            else if (frame_done) done_flag <= 1'b1;
        end
    end

    // Registered dispatch: grant, coordinates and raster pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_start <= '0;
            disp_h     <= '0;
            disp_v     <= '0;
            dsp_rr     <= '0;
            ptr_h      <= '0;
            ptr_v      <= '0;
        end else begin
            core_start <= '0;
            if (enter) begin
                ptr_h <= '0;
                ptr_v <= '0;
            end else if (dsp_fire) begin
                core_start <= N_CORES'(1) << dsp_g;
                disp_h     <= ptr_h;
                disp_v     <= ptr_v;
                dsp_rr     <= rr_next(dsp_g);
                if (ptr_h == 11'(H_RES - 1)) begin
                    ptr_h <= '0;
                    ptr_v <= ptr_v + 10'd1;
                end else begin
                    ptr_h <= ptr_h + 11'd1;
                end
            end
        end
    end

    // Combinational one-hot accept toward the winning core.
    always_comb begin
        res_ready = '0;
        if (col_fire) res_ready[col_g] = 1'b1;
    end

    // Single-entry output register; holds steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_h     <= '0;
            out_v     <= '0;
            col_rr    <= '0;
        end else if (col_fire) begin
            out_valid <= 1'b1;
            out_pixel <= res_pixel[16*col_g +: 16];
            out_h     <= res_h[11*col_g +: 11];
            out_v     <= res_v[10*col_g +: 10];
            col_rr    <= rr_next(col_g);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pixels written this frame; frame_done keys off the final handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        out_cnt <= '0;
        else if (enter) out_cnt <= '0;
        else if (hs)    out_cnt <= out_cnt + CNT_W'(1);
    end

`ifdef RTX_SCHED_STATS_EN
    logic [31:0] cyc_cnt;
    logic [3:0]  inflight, peak, peak_now;

    assign peak_now = (inflight > peak) ? inflight : peak;

    // Per-frame cycle count and peak outstanding jobs, latched at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt      <= '0;
            inflight     <= '0;
            peak         <= '0;
            frame_cycles <= '0;
            max_inflight <= '0;
        end else begin
            if (enter) begin
                cyc_cnt  <= '0;
                inflight <= '0;
                peak     <= '0;
            end else if (state != IDLE) begin
                if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
                if ((|core_start) && !hs && (inflight != 4'hF))
                    inflight <= inflight + 4'd1;
                else if (!(|core_start) && hs && (inflight != 4'd0))
                    inflight <= inflight - 4'd1;
                peak <= peak_now;
            end
            if (frame_done) begin
                frame_cycles <= (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
                max_inflight <= peak_now;
            end
        end
    end
`endif

endmodule

// File: doc/rtx_pixel_scheduler.md
Name: rtx_pixel_scheduler

Overview:
Sequences a full frame of ray-tracing work across N_CORES rtx cores. It dispatches pixel coordinates in raster order to idle cores. It round-robin arbitrates their finished pixels onto a single valid/ready write port that feeds the frame-buffer write side (camera_valid/camera_pixel/camera_h_count/camera_v_count). It sits between the rtx cores and high_definition_frame_buffer, in the clk_camera domain.

Parameters:
N_CORES, 4, number of rtx cores served (1..8)
H_RES, 1280, pixels per line
V_RES, 720, lines per frame
CONTINUOUS, 0, 1 = restart the next frame automatically after frame_done

Ports:
clk  input  1  clock (clk_camera domain)
rst  input  1  asynchronous reset, active-high
start  input  1  pulse; begins a frame when in IDLE
stop  input  1  level; while high, no new dispatches are issued (in-flight work still drains)
core_ready  input  N_CORES  core i can accept a job
core_start  output  N_CORES  one-hot, 1-cycle pulse; job issued to core i
disp_h  output  11  job column, valid with any core_start bit
disp_v  output  10  job row, valid with any core_start bit
res_valid  input  N_CORES  core i holds a finished pixel
res_ready  output  N_CORES  one-hot; core i's result consumed this cycle
res_pixel  input  16*N_CORES  RGB565 per core, slice i = [16i+15:16i]
res_h  input  11*N_CORES  column per core
res_v  input  10*N_CORES  row per core
out_valid  output  1  pixel available to frame buffer
out_ready  input  1  frame buffer accepts (tie 1 if no backpressure)
out_pixel  output  16  RGB565
out_h  output  11  column
out_v  output  10  row
busy  output  1  state != IDLE
frame_done  output  1  1-cycle pulse when the last pixel of a frame leaves the output port

Behaviour:
- Reset (async, rst=1): state=IDLE, dispatch pointer (h,v)=(0,0), rr pointers=0, out count=0.
- Outputs at reset: core_start=0, res_ready=0, out_valid=0, out_pixel/out_h/out_v=0, disp_h/disp_v=0, busy=0, frame_done=0.
- Reset mid-frame drops all in-flight state; the cores are reset by the same rst.
- FSM IDLE -> DISPATCH:
  - start=1, or CONTINUOUS=1 and the previous frame is done.
  - Entry clears the pointer and out count.
  - start is ignored outside IDLE.
- FSM DISPATCH:
  - Each cycle, if stop=0 and core_ready has any bit set, grant exactly one core: the first ready index at or after dsp_rr, wrapping.
  - The grant is registered: core_start, disp_h and disp_v appear the cycle after the decision.
  - The granted core must not be re-granted on the cycle its core_start is high; the core drops core_ready on seeing core_start.
  - dsp_rr becomes grant+1 mod N_CORES.
  - Pointer advance: h++; at h=H_RES-1, h wraps to 0 and v++.
  - After issuing (H_RES-1, V_RES-1) -> DRAIN.
- FSM DRAIN: no dispatches. When out count reaches H_RES*V_RES with the final handshake -> IDLE. The frame_done pulse coincides with that final out_valid&&out_ready cycle.
- Collection runs independently in DISPATCH and DRAIN and ignores res_valid in IDLE. Single output register:
  - The register can load when out_valid=0, or when out_valid&&out_ready.
  - When it can load and res_valid != 0, grant the first valid index at or after col_rr, wrapping.
  - The granted core gets res_ready high combinationally that cycle. Its pixel, h and v load into the output register, and out_valid=1 next cycle (latency 1).
  - col_rr becomes grant+1.
  - Full throughput: 1 pixel/cycle when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_* hold stable and res_ready=0.
- Out counter: ceil(log2(H_RES*V_RES+1)) bits; increments on each out_valid&&out_ready.
- Simultaneous events: dispatch and collection are independent and may involve the same core in the same cycle.
- Stop: deasserting stop resumes at the saved pointer. Stop held through DRAIN has no effect on draining.

Optional Feature:
RTX_SCHED_STATS_EN
- Defined: adds output frame_cycles[31:0] and output max_inflight[3:0].
  - frame_cycles counts clocks from IDLE exit to frame_done (saturating at 2^32-1) and is latched on frame_done.
  - max_inflight is the peak of (dispatched - written) within the frame and is latched on frame_done.
  - Both outputs reset to 0.
- Undefined: neither port nor either counter exists.

Test Plan:
- N_CORES=4, H_RES=4, V_RES=2, all cores ready, each returns a result 3 cycles after start, out_ready=1 -> 8 dispatches in raster order (0,0)..(3,1), core_start pattern 0001,0010,0100,1000,0001..; exactly 8 out beats; frame_done high on the 8th beat; busy falls the next cycle.
- All 4 res_valid high together, out_ready=1 -> res_ready grants 0001,0010,0100,1000 on consecutive cycles; out beats in that order.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_pixel/out_h/out_v unchanged and res_ready=0 all 5 cycles; on out_ready=1, the next grant follows the rr order.
- stop=1 after 3 dispatches for 10 cycles -> no core_start during the hold; the next dispatch is (3,0).
- rst asserted mid-DISPATCH -> all outputs 0 asynchronously; after release, start restarts at (0,0) with core 0.
- CONTINUOUS=1, 2 frames -> two frame_done pulses with no IDLE gap beyond 1 cycle. With RTX_SCHED_STATS_EN, frame_cycles equals the measured clock count and max_inflight ≤ 4.
